// File: rtl/count_disp_pkg.sv
// Shared types and 7-segment helpers for the count-to-display path.
package count_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Segment patterns ordered {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Nibble to segment pattern; non-decimal nibbles show nothing.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble converter with a single-entry pending slot so
// loads arriving mid-conversion are queued (last one wins).
module bin2bcd_iter #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      count_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  bcd_valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);
    import count_disp_pkg::*;

    localparam int BCD_W = 4 * DIGITS;
    localparam int TOT_W = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    conv_state_t         state_r,    state_s;
    logic [TOT_W-1:0]    sreg_r,     sreg_s;
    logic [CNT_W-1:0]    bit_cnt_r,  bit_cnt_s;
    logic                ovf_acc_r,  ovf_acc_s;
    logic                pend_r,     pend_s;
    logic [WIDTH-1:0]    pend_val_r, pend_val_s;
    logic                busy_r,     busy_s;
    logic                valid_r,    valid_s;
    logic [BCD_W-1:0]    bcd_r,      bcd_s;
    logic                ovf_r,      ovf_s;

    logic [TOT_W-1:0]    corr_s;
    logic [TOT_W-1:0]    shifted_s;
    logic                shout_s;

    // One double-dabble step: add 3 to nibbles >= 5, then shift left.
    always_comb begin
        corr_s = sreg_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (sreg_r[WIDTH+4*i +: 4] >= 4'd5) begin
                corr_s[WIDTH+4*i +: 4] = sreg_r[WIDTH+4*i +: 4] + 4'd3;
            end else begin
                corr_s[WIDTH+4*i +: 4] = sreg_r[WIDTH+4*i +: 4];
            end
        end
        shifted_s = {corr_s[TOT_W-2:0], 1'b0};
        shout_s   = corr_s[TOT_W-1];
    end

    // Next-state and datapath control for the conversion FSM.
    always_comb begin
        state_s    = state_r;
        sreg_s     = sreg_r;
        bit_cnt_s  = bit_cnt_r;
        ovf_acc_s  = ovf_acc_r;
        pend_s     = pend_r;
        pend_val_s = pend_val_r;
        valid_s    = 1'b0;
        bcd_s      = bcd_r;
        ovf_s      = ovf_r;
        case (state_r)
            IDLE: begin
                if (load) begin
                    sreg_s    = {{BCD_W{1'b0}}, count_in};
                    bit_cnt_s = CNT_W'(WIDTH);
                    ovf_acc_s = 1'b0;
                    state_s   = SHIFT;
                end else begin
                    state_s   = IDLE;
                end
            end
            SHIFT: begin
                sreg_s    = shifted_s;
                ovf_acc_s = ovf_acc_r | shout_s;
                bit_cnt_s = bit_cnt_r - CNT_W'(1);
                if (bit_cnt_r == CNT_W'(1)) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
                if (load) begin
                    pend_s     = 1'b1;
                    pend_val_s = count_in;
                end else begin
                    pend_s     = pend_r;
                end
            end
            DONE: begin
                valid_s = 1'b1;
                bcd_s   = sreg_r[TOT_W-1 -: BCD_W];
                ovf_s   = ovf_acc_r;
                if (load || pend_r) begin
                    // A load landing in this cycle is newer than the slot.
                    sreg_s    = {{BCD_W{1'b0}}, (load ? count_in : pend_val_r)};
                    pend_s    = 1'b0;
                    bit_cnt_s = CNT_W'(WIDTH);
                    ovf_acc_s = 1'b0;
                    state_s   = SHIFT;
                end else begin
                    state_s   = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and output registers; rst_n is an active-high async clear.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r    <= IDLE;
            sreg_r     <= {TOT_W{1'b0}};
            bit_cnt_r  <= {CNT_W{1'b0}};
            ovf_acc_r  <= 1'b0;
            pend_r     <= 1'b0;
            pend_val_r <= {WIDTH{1'b0}};
            busy_r     <= 1'b0;
            valid_r    <= 1'b0;
            bcd_r      <= {BCD_W{1'b0}};
            ovf_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            sreg_r     <= sreg_s;
            bit_cnt_r  <= bit_cnt_s;
            ovf_acc_r  <= ovf_acc_s;
            pend_r     <= pend_s;
            pend_val_r <= pend_val_s;
            busy_r     <= busy_s;
            valid_r    <= valid_s;
            bcd_r      <= bcd_s;
            ovf_r      <= ovf_s;
        end
    end

    assign busy      = busy_r;
    assign bcd_valid = valid_r;
    assign bcd_out   = bcd_r;
    assign overflow  = ovf_r;

endmodule

// File: rtl/count_bcd_7seg_display.sv
// Binary count to multiplexed 7-segment display: BCD conversion plus
// refresh scan, leading-zero blanking and overflow dash.
module count_bcd_7seg_display #(
    parameter int WIDTH       = 10,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      count_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  bcd_valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     digit_sel
);
    import count_disp_pkg::*;

    localparam int RC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS-1:0] SEL_ONE = DIGITS'(1);

    logic [RC_W-1:0]   ref_cnt_r, ref_cnt_s;
    logic [IDX_W-1:0]  idx_r,     idx_s;
    logic [6:0]        seg_r,     seg_s;
    logic [DIGITS-1:0] sel_r,     sel_s;
    logic [3:0]        nib_s;
    logic              upper_nz_s;

    bin2bcd_iter #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk       (clk),
        .rst_n     (rst_n),
        .count_in  (count_in),
        .load      (load),
        .busy      (busy),
        .bcd_valid (bcd_valid),
        .bcd_out   (bcd_out),
        .overflow  (overflow)
    );

    // Refresh divider and digit index advance.
    always_comb begin
        if (ref_cnt_r == RC_W'(REFRESH_DIV - 1)) begin
            ref_cnt_s = RC_W'(0);
            if (idx_r == IDX_W'(DIGITS - 1)) begin
                idx_s = IDX_W'(0);
            end else begin
                idx_s = idx_r + IDX_W'(1);
            end
        end else begin
            ref_cnt_s = ref_cnt_r + RC_W'(1);
            idx_s     = idx_r;
        end
    end

    // Pick the active nibble and see whether it or any higher digit is nonzero.
    always_comb begin
        nib_s      = 4'd0;
        upper_nz_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (int'(idx_r) == i) begin
                nib_s = bcd_out[4*i +: 4];
            end else begin
                nib_s = nib_s;
            end
            if ((i >= int'(idx_r)) && (bcd_out[4*i +: 4] != 4'd0)) begin
                upper_nz_s = 1'b1;
            end else begin
                upper_nz_s = upper_nz_s;
            end
        end
    end

    // Segment pattern: overflow dash beats blanking beats the digit itself.
    always_comb begin
        sel_s = SEL_ONE << idx_r;
        if (overflow) begin
            seg_s = SEG_DASH;
        end else if ((BLANK_LZ != 0) && (idx_r != IDX_W'(0)) && !upper_nz_s) begin
            seg_s = SEG_BLANK;
        end else begin
            seg_s = seg_decode(nib_s);
        end
    end

    // Scan registers and registered display outputs.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ref_cnt_r <= {RC_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            seg_r     <= 7'b0000000;
            sel_r     <= {DIGITS{1'b0}};
        end else begin
            ref_cnt_r <= ref_cnt_s;
            idx_r     <= idx_s;
            seg_r     <= seg_s;
            sel_r     <= sel_s;
        end
    end

    assign seg       = seg_r;
    assign digit_sel = sel_r;

endmodule

// File: tb/tb_count_bcd_7seg_display.sv
// Self-checking bench: three instances (A: 10b/4dig/div4, B: 14b/3dig/div2,
// C: 10b/4dig/div1) exercised by directed sequences, a table and a random run.
module tb_count_bcd_7seg_display;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int rel_a = 0, rel_b = 0, rel_c = 0;

    logic        rst_a, load_a, busy_a, valid_a, ovf_a;
    logic [9:0]  cnt_a;
    logic [15:0] bcd_a;
    logic [6:0]  seg_a;
    logic [3:0]  sel_a;

    logic        rst_b, load_b, busy_b, valid_b, ovf_b;
    logic [13:0] cnt_b;
    logic [11:0] bcd_b;
    logic [6:0]  seg_b;
    logic [2:0]  sel_b;

    logic        rst_c, load_c, busy_c, valid_c, ovf_c;
    logic [9:0]  cnt_c;
    logic [15:0] bcd_c;
    logic [6:0]  seg_c;
    logic [3:0]  sel_c;

    count_bcd_7seg_display #(.WIDTH(10), .DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1)) dut_a (
        .clk(clk), .rst_n(rst_a), .count_in(cnt_a), .load(load_a), .busy(busy_a),
        .bcd_valid(valid_a), .bcd_out(bcd_a), .overflow(ovf_a), .seg(seg_a), .digit_sel(sel_a));

    count_bcd_7seg_display #(.WIDTH(14), .DIGITS(3), .REFRESH_DIV(2), .BLANK_LZ(1)) dut_b (
        .clk(clk), .rst_n(rst_b), .count_in(cnt_b), .load(load_b), .busy(busy_b),
        .bcd_valid(valid_b), .bcd_out(bcd_b), .overflow(ovf_b), .seg(seg_b), .digit_sel(sel_b));

    count_bcd_7seg_display #(.WIDTH(10), .DIGITS(4), .REFRESH_DIV(1), .BLANK_LZ(1)) dut_c (
        .clk(clk), .rst_n(rst_c), .count_in(cnt_c), .load(load_c), .busy(busy_c),
        .bcd_valid(valid_c), .bcd_out(bcd_c), .overflow(ovf_c), .seg(seg_c), .digit_sel(sel_c));

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        int         val;
        logic [11:0] bcd;
        bit         ovf;
    } vec_t;
    vec_t tab [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected pattern for digit position idx of a decimal value.
    function automatic logic [6:0] seg_model(input int val, input bit ovf, input int idx);
        int p;
        p = 1;
        for (int j = 0; j < idx; j++) p = p * 10;
        if (ovf) return 7'b1000000;
        if (idx > 0 && val < p) return 7'b0000000;
        return seg_tab[(val / p) % 10];
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int nd);
        logic [31:0] r;
        int p;
        r = 32'd0;
        p = 1;
        for (int j = 0; j < nd; j++) begin
            r = r | (32'((v / p) % 10) << (4 * j));
            p = p * 10;
        end
        return r;
    endfunction

    // Step n cycles checking scan position and pattern for a stable value.
    task automatic check_display(input int which, input int val, input bit ovf, input int n);
        int rd, nd, rel, e, idx;
        logic [6:0] s;
        logic [3:0] d;
        for (int k = 0; k < n; k++) begin
            step();
            case (which)
                0:       begin rd = 4; nd = 4; rel = rel_a; s = seg_a; d = sel_a; end
                1:       begin rd = 2; nd = 3; rel = rel_b; s = seg_b; d = {1'b0, sel_b}; end
                default: begin rd = 1; nd = 4; rel = rel_c; s = seg_c; d = sel_c; end
            endcase
            e   = cyc - rel;
            idx = ((e - 1) / rd) % nd;
            chk("digit_sel", 32'(d), 32'(1 << idx));
            chk("seg", 32'(s), 32'(seg_model(val, ovf, idx)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit   l, exp_valid, m_active, m_pend;
        int   x, t, e, idx, lat, m_start, m_cur, m_pval, disp, prev;

        tab[0] = '{1000,  12'h000, 1'b1};
        tab[1] = '{999,   12'h999, 1'b0};
        tab[2] = '{16383, 12'h000, 1'b1};
        tab[3] = '{0,     12'h000, 1'b0};
        tab[4] = '{500,   12'h500, 1'b0};
        tab[5] = '{7,     12'h007, 1'b0};
        tab[6] = '{120,   12'h120, 1'b0};
        tab[7] = '{1001,  12'h000, 1'b1};
        tab[8] = '{10,    12'h010, 1'b0};

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
        cnt_a = 10'd0; cnt_b = 14'd0; cnt_c = 10'd0;
        repeat (3) step();

        // Reset state
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_bcd", 32'(bcd_a), 32'd0);
        chk("rst_ovf", 32'(ovf_a), 32'd0);
        chk("rst_seg", 32'(seg_a), 32'd0);
        chk("rst_sel", 32'(sel_a), 32'd0);
        rst_a = 1'b0; rel_a = cyc;
        step();
        chk("first_sel", 32'(sel_a), 32'd1);
        chk("first_seg", 32'(seg_a), 32'(7'b0111111));

        // Basic conversion of 1023
        for (int k = 0; k <= 13; k++) begin
            load_a = (k == 0); cnt_a = 10'd1023;
            step();
            chk("basic_valid", 32'(valid_a), 32'(k == 11));
            if (k == 0)  chk("basic_busy0", 32'(busy_a), 32'd1);
            if (k == 10) chk("basic_busy10", 32'(busy_a), 32'd1);
            if (k == 11) begin
                chk("basic_busy11", 32'(busy_a), 32'd0);
                chk("basic_bcd", 32'(bcd_a), 32'h1023);
                chk("basic_ovf", 32'(ovf_a), 32'd0);
            end
        end
        load_a = 1'b0;

        // Reset asserted during SHIFT
        for (int k = 0; k <= 3; k++) begin
            load_a = (k == 0); cnt_a = 10'd999;
            step();
        end
        load_a = 1'b0;
        rst_a = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy_a), 32'd0);
        chk("mid_rst_bcd", 32'(bcd_a), 32'd0);
        chk("mid_rst_seg", 32'(seg_a), 32'd0);
        chk("mid_rst_sel", 32'(sel_a), 32'd0);
        step(); step();
        chk("mid_rst_valid", 32'(valid_a), 32'd0);
        rst_a = 1'b0; rel_a = cyc;
        step();
        chk("mid_rel_sel", 32'(sel_a), 32'd1);
        chk("mid_rel_seg", 32'(seg_a), 32'(7'b0111111));
        for (int k = 0; k < 14; k++) begin
            step();
            chk("mid_no_valid", 32'(valid_a), 32'd0);
            chk("mid_no_busy", 32'(busy_a), 32'd0);
        end

        // Back-to-back loads: 5, then 6 and 7 while busy (7 wins)
        for (int k = 0; k <= 24; k++) begin
            load_a = (k == 0) || (k == 3) || (k == 5);
            cnt_a  = (k == 0) ? 10'd5 : ((k == 3) ? 10'd6 : 10'd7);
            step();
            chk("b2b_valid", 32'(valid_a), 32'((k == 11) || (k == 22)));
            if (k == 11) chk("b2b_bcd5", 32'(bcd_a), 32'h0005);
            if (k == 12) chk("b2b_busy", 32'(busy_a), 32'd1);
            if (k == 22) chk("b2b_bcd7", 32'(bcd_a), 32'h0007);
            if (k == 23) chk("b2b_idle", 32'(busy_a), 32'd0);
        end
        load_a = 1'b0;

        // Zero with leading-zero blanking
        for (int k = 0; k <= 11; k++) begin
            load_a = (k == 0); cnt_a = 10'd0;
            step();
        end
        load_a = 1'b0;
        chk("zero_valid", 32'(valid_a), 32'd1);
        chk("zero_bcd", 32'(bcd_a), 32'd0);
        check_display(0, 0, 1'b0, 20);

        // Random loads against a timing/value model
        m_active = 1'b0; m_pend = 1'b0; m_start = 0; m_cur = 0; m_pval = 0; disp = 0;
        for (int i = 0; i < 340; i++) begin
            l = (i < 300) && ($urandom_range(0, 5) == 0);
            x = int'($urandom_range(0, 1023));
            load_a = l; cnt_a = 10'(x);
            prev = disp;
            step();
            t = cyc;
            exp_valid = 1'b0;
            if (m_active && t == m_start + 11) begin
                exp_valid = 1'b1;
                disp = m_cur;
                if (l) begin m_pend = 1'b1; m_pval = x; end
                if (m_pend) begin
                    m_cur = m_pval; m_start = t; m_pend = 1'b0;
                end else begin
                    m_active = 1'b0;
                end
            end else if (m_active) begin
                if (l) begin m_pend = 1'b1; m_pval = x; end
            end else if (l) begin
                m_active = 1'b1; m_start = t; m_cur = x;
            end
            e   = t - rel_a;
            idx = ((e - 1) / 4) % 4;
            chk("rnd_valid", 32'(valid_a), 32'(exp_valid));
            chk("rnd_busy", 32'(busy_a), 32'(m_active));
            chk("rnd_bcd", 32'(bcd_a), to_bcd(disp, 4));
            chk("rnd_ovf", 32'(ovf_a), 32'd0);
            chk("rnd_sel", 32'(sel_a), 32'(1 << idx));
            chk("rnd_seg", 32'(seg_a), 32'(seg_model(prev, 1'b0, idx)));
        end
        load_a = 1'b0;

        // Table: 14-bit input into 3 digits, overflow and recovery
        rst_b = 1'b0; rel_b = cyc;
        step();
        chk("b_first_sel", 32'(sel_b), 32'd1);
        chk("b_first_seg", 32'(seg_b), 32'(7'b0111111));
        for (int i = 0; i < 9; i++) begin
            load_b = 1'b1; cnt_b = 14'(tab[i].val);
            step();
            load_b = 1'b0;
            lat = 0;
            while (valid_b !== 1'b1 && lat < 30) begin
                step();
                lat++;
            end
            chk("b_latency", 32'(lat), 32'd15);
            chk("b_ovf", 32'(ovf_b), 32'(tab[i].ovf));
            if (!tab[i].ovf) chk("b_bcd", 32'(bcd_b), 32'(tab[i].bcd));
            check_display(1, tab[i].val, tab[i].ovf, 8);
        end

        // Refresh divider of 1: one digit per cycle
        chk("c_rst_seg", 32'(seg_c), 32'd0);
        chk("c_rst_sel", 32'(sel_c), 32'd0);
        rst_c = 1'b0; rel_c = cyc;
        check_display(2, 0, 1'b0, 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
